// File: rtl/pong_game_ctrl.sv
// ============================================================================
//  Module      : pong_game_ctrl
//  Description : Pong match sequencer. Gates paddle/ball motion, judges hits
//                at the goal lines, keeps scores and runs the match flow.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pong_game_ctrl #(
    parameter logic [9:0] LEFT_X       = 10'd16,
    parameter logic [9:0] RIGHT_X      = 10'd624,
    parameter logic [9:0] PADDLE_H     = 10'd64,
    parameter logic [3:0] WIN_SCORE    = 4'd7,
    parameter logic [7:0] SERVE_FRAMES = 8'd60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] ball_pos_x,
    input  logic [9:0] ball_pos_y,
    input  logic [9:0] player_paddle,
    input  logic [9:0] ai_paddle,
    output logic       move_en,
    output logic       ball_hold,
    output logic       serve_dir,
    output logic       hit_left,
    output logic       hit_right,
    output logic [3:0] player_score,
    output logic [3:0] ai_score,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [10:0] c_paddle_h = {1'b0, PADDLE_H};

    state_t      r_state;
    logic [7:0]  r_serve_cnt;
    logic        r_start_q;
    logic        r_start_pulse;

    logic [10:0] w_ball_y;
    logic [10:0] w_left_top;
    logic [10:0] w_right_top;
    logic        w_left_in;
    logic        w_right_in;
    logic [7:0]  w_serve_next;

    // Widened to 11 bits so a paddle near the bottom cannot wrap its window
    assign w_ball_y     = {1'b0, ball_pos_y};
    assign w_left_top   = {1'b0, player_paddle};
    assign w_right_top  = {1'b0, ai_paddle};
    assign w_left_in    = (w_ball_y >= w_left_top)  && (w_ball_y < (w_left_top  + c_paddle_h));
    assign w_right_in   = (w_ball_y >= w_right_top) && (w_ball_y < (w_right_top + c_paddle_h));
    assign w_serve_next = r_serve_cnt + 8'd1;

    assign ball_hold = (r_state != S_PLAY);
    assign game_over = (r_state == S_OVER);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_serve_cnt   <= 8'd0;
            r_start_q     <= 1'b0;
            r_start_pulse <= 1'b0;
            move_en       <= 1'b0;
            serve_dir     <= 1'b0;
            hit_left      <= 1'b0;
            hit_right     <= 1'b0;
            player_score  <= 4'd0;
            ai_score      <= 4'd0;
            winner        <= 1'b0;
        end else begin
            r_start_q     <= start;
            r_start_pulse <= start & ~r_start_q;
            hit_left      <= 1'b0;
            hit_right     <= 1'b0;
            move_en       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_start_pulse) begin
                        r_state     <= S_SERVE;
                        r_serve_cnt <= 8'd0;
                    end
                end

                S_SERVE: begin
                    move_en <= frame_tick;
                    if (frame_tick) begin
                        r_serve_cnt <= w_serve_next;
                        if (w_serve_next == SERVE_FRAMES) begin
                            r_state <= S_PLAY;
                        end
                    end
                end

                S_PLAY: begin
                    move_en <= frame_tick;
                    if (frame_tick) begin
                        // Left goal line is judged first when both could apply
                        if (ball_pos_x <= LEFT_X) begin
                            if (w_left_in) begin
                                hit_left <= 1'b1;
                            end else begin
                                if (ai_score < WIN_SCORE) begin
                                    ai_score <= ai_score + 4'd1;
                                end
                                serve_dir <= 1'b0;
                                r_state   <= S_POINT;
                            end
                        end else if (ball_pos_x >= RIGHT_X) begin
                            if (w_right_in) begin
                                hit_right <= 1'b1;
                            end else begin
                                if (player_score < WIN_SCORE) begin
                                    player_score <= player_score + 4'd1;
                                end
                                serve_dir <= 1'b1;
                                r_state   <= S_POINT;
                            end
                        end
                    end
                end

                S_POINT: begin
                    if ((player_score == WIN_SCORE) || (ai_score == WIN_SCORE)) begin
                        r_state <= S_OVER;
                        winner  <= (ai_score == WIN_SCORE);
                    end else begin
                        r_state     <= S_SERVE;
                        r_serve_cnt <= 8'd0;
                    end
                end

                S_OVER: begin
                    if (r_start_pulse) begin
                        player_score <= 4'd0;
                        ai_score     <= 4'd0;
                        serve_dir    <= 1'b0;
                        r_serve_cnt  <= 8'd0;
                        r_state      <= S_SERVE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
